restoring_divider_seq: RTL and testbench
========================================

Name: restoring_divider_seq

Overview:
Sequential radix-2 restoring divider; the inverse datapath of the team's iterative multiplier.
- Takes a (QUOT_WIDTH+DIV_WIDTH)-bit dividend (e.g. a full multiplier product) and a DIV_WIDTH-bit divisor.
- Produces a QUOT_WIDTH-bit quotient and a DIV_WIDTH-bit remainder.
- Used for product round-trip checking and for normalisation in the arithmetic path.
- Retires one quotient bit per clock (two with the optional feature) behind a start/busy/rdy handshake.

Parameters:
- QUOT_WIDTH, 64, quotient width; also the number of radix-2 iterations.
- DIV_WIDTH, 64, divisor and remainder width; dividend width is QUOT_WIDTH+DIV_WIDTH.

Ports:
- clk  input  1  rising-edge clock.
- rst  input  1  reset; one clock, asynchronous assert, active-low.
- start  input  1  request; sampled only when busy=0.
- in0  input  QUOT_WIDTH+DIV_WIDTH  dividend.
- in1  input  DIV_WIDTH  divisor.
- quot  output  QUOT_WIDTH  quotient.
- rem  output  DIV_WIDTH  remainder.
- rdy  output  1  one-cycle pulse: results valid.
- busy  output  1  operation in progress.
- div_by_zero  output  1  last operation had in1==0.
- overflow  output  1  last operation had a quotient that does not fit (in1!=0 and in0[hi DIV_WIDTH bits] >= in1).

Behaviour:
- Reset (rst low, asynchronous): state=IDLE; quot, rem, rdy, busy, div_by_zero, overflow all 0. Reset mid-operation aborts with no rdy pulse. Deassertion takes effect at the next clk edge.
- States: IDLE, CALC, DONE.
- IDLE, start=1 at edge T: latch in1. Outputs keep their previous values until DONE.
  - in1==0: div_by_zero=1, overflow=0, quot=all ones, rem=in0[DIV_WIDTH-1:0]; go to DONE.
  - else if in0[hi]>=in1: overflow=1, div_by_zero=0, quot=all ones, rem=0; go to DONE.
  - else: R (DIV_WIDTH+1 bits) = {0, in0[hi]}; shift register Q = in0[QUOT_WIDTH-1:0]; counter = QUOT_WIDTH-1; busy=1; go to CALC.
- CALC, each edge:
  - T = {R[DIV_WIDTH-1:0], Q msb} - {0, in1}.
  - If T is non-negative: R = T and the new quotient bit = 1. Otherwise R is the shifted value and the bit = 0.
  - Q shifts left, taking the new bit into the lsb. Counter decrements.
  - At counter==0 go to DONE.
- DONE (one cycle): rdy=1, busy=0. quot/rem/flags are registered on entry and held until the next accepted start. Next state is IDLE.
- Latency, measured from the edge sampling start to the edge asserting rdy:
  - normal operation: QUOT_WIDTH+1 edges;
  - error cases: 1 edge.
- start while busy=1, or during the DONE cycle: ignored, no queueing.
- Flags clear on the next accepted start.
- Invariant for non-error results: in0 == quot*in1 + rem, with rem < in1.

Optional Feature:
- Macro: DIVIDER_RADIX4_EN.
- Defined: two cascaded restoring steps per CALC cycle. The counter starts at QUOT_WIDTH/2-1, so normal latency = QUOT_WIDTH/2+1 edges. QUOT_WIDTH must be even; elaboration error otherwise.
- Undefined: radix-2 exactly as above.
- Outputs, flags and error latency are identical either way.

Decomposition:
- Shared package arith_pkg holds:
  - state enum {IDLE, CALC, DONE};
  - localparams DIVIDEND_WIDTH = QUOT_WIDTH+DIV_WIDTH and ITER_CNT_WIDTH = clog2(QUOT_WIDTH);
  - a function computing the all-ones quotient constant.
- Sub-module div_step: purely combinational. It maps (R, next dividend bit, divisor) to (new R, quotient bit). It is instantiated once, or twice in cascade under DIVIDER_RADIX4_EN, mirroring how the compressor is split out of the multiplier.

Test Plan:
- in0=100, in1=7 -> quot=14, rem=2, overflow=0, div_by_zero=0; rdy exactly 65 edges after start (33 with DIVIDER_RADIX4_EN).
- in0=5<<64, in1=6 -> quot=64'hD555555555555555, rem=2.
- in1=0, in0=128'h1234 -> div_by_zero=1, quot=64'hFFFFFFFFFFFFFFFF, rem=64'h1234; rdy 1 edge after start.
- in0=5<<64, in1=5 -> overflow=1, quot=all ones, rem=0. Then a clean op (100/7) -> flags clear.
- start pulsed every cycle during an operation -> only the first is accepted, and exactly one rdy pulse is seen. rst low at iteration 30 -> all outputs 0 immediately, no rdy. A new start after release -> correct result.
- 1000 random (a,b) pairs with b!=0: feed a*b+r for random r<b -> quot=a, rem=r.

Source files
------------

// File: rtl/arith_pkg.sv
// Shared arithmetic-path definitions: divider FSM states, default widths and
// the saturated quotient constant used on divide-by-zero and overflow.
package arith_pkg;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    CALC = 2'd1,
    DONE = 2'd2
  } div_state_t;

  localparam int QUOT_WIDTH_DEF = 64;
  localparam int DIV_WIDTH_DEF  = 64;
  localparam int DIVIDEND_WIDTH = QUOT_WIDTH_DEF + DIV_WIDTH_DEF;
  localparam int ITER_CNT_WIDTH = $clog2(QUOT_WIDTH_DEF);

  localparam int MAX_QUOT_WIDTH = 256;

  // Low 'width' bits set; callers truncate to their own quotient width.
  function automatic logic [MAX_QUOT_WIDTH-1:0] quot_all_ones(input int unsigned width);
    logic [MAX_QUOT_WIDTH-1:0] ones;
    ones = '1;
    return ones >> (MAX_QUOT_WIDTH - width);
  endfunction

endpackage

// File: rtl/div_step.sv
// One radix-2 restoring step: shift the next dividend bit into the partial
// remainder, trial-subtract the divisor and restore when the result is negative.
module div_step #(
  parameter int DIV_WIDTH = 64
) (
  input  logic [DIV_WIDTH:0]   r_in,
  input  logic                 dvd_bit,
  input  logic [DIV_WIDTH-1:0] divisor,
  output logic [DIV_WIDTH:0]   r_out,
  output logic                 q_bit
);

  logic        [DIV_WIDTH:0] shifted;
  logic signed [DIV_WIDTH:0] trial;

  always_comb begin
    shifted = {r_in[DIV_WIDTH-1:0], dvd_bit};
    trial   = $signed(shifted) - $signed({1'b0, divisor});
    // A set remainder msb would mean the shifted value already exceeds any divisor.
    q_bit   = ~trial[DIV_WIDTH] | r_in[DIV_WIDTH];
    r_out   = q_bit ? $unsigned(trial) : shifted;
  end

endmodule

// File: rtl/restoring_divider_seq.sv
// Sequential restoring divider, one quotient bit per clock behind start/busy/rdy.
// Define DIVIDER_RADIX4_EN to cascade two steps per cycle (QUOT_WIDTH must be even).
module restoring_divider_seq
  import arith_pkg::*;
#(
  parameter int QUOT_WIDTH = QUOT_WIDTH_DEF,
  parameter int DIV_WIDTH  = DIV_WIDTH_DEF
) (
  input  logic                            clk,
  input  logic                            rst,
  input  logic                            start,
  input  logic [QUOT_WIDTH+DIV_WIDTH-1:0] in0,
  input  logic [DIV_WIDTH-1:0]            in1,
  output logic [QUOT_WIDTH-1:0]           quot,
  output logic [DIV_WIDTH-1:0]            rem,
  output logic                            rdy,
  output logic                            busy,
  output logic                            div_by_zero,
  output logic                            overflow
);

  localparam int DVD_W = QUOT_WIDTH + DIV_WIDTH;
  localparam int CNT_W = (QUOT_WIDTH > 1) ? $clog2(QUOT_WIDTH) : 1;
`ifdef DIVIDER_RADIX4_EN
  localparam int STEPS_PER_CYC = 2;
`else
  localparam int STEPS_PER_CYC = 1;
`endif
  localparam logic [CNT_W-1:0]      CNT_INIT  = CNT_W'(QUOT_WIDTH / STEPS_PER_CYC - 1);
  localparam logic [QUOT_WIDTH-1:0] QUOT_ONES = QUOT_WIDTH'(quot_all_ones(QUOT_WIDTH));

  div_state_t state, state_nxt;

  logic [DIV_WIDTH:0]      r_q;
  logic [QUOT_WIDTH-1:0]   q_q;
  logic [DIV_WIDTH-1:0]    dsr_q;
  logic [CNT_W-1:0]        cnt_q;

  logic [DIV_WIDTH-1:0]    dvd_hi;
  logic [QUOT_WIDTH-1:0]   dvd_lo;
  logic                    accept;
  logic                    in_dz;
  logic                    in_ovf;
  logic                    last_iter;

  logic [DIV_WIDTH:0]      r_s0;
  logic                    qb0;
  logic [DIV_WIDTH:0]      r_nxt;
  logic [QUOT_WIDTH-1:0]   q_nxt;

  assign dvd_hi    = in0[DVD_W-1 -: DIV_WIDTH];
  assign dvd_lo    = in0[QUOT_WIDTH-1:0];
  assign accept    = (state == IDLE) && start;
  assign in_dz     = (in1 == '0);
  assign in_ovf    = !in_dz && (dvd_hi >= in1);
  assign last_iter = (state == CALC) && (cnt_q == '0);

  div_step #(.DIV_WIDTH(DIV_WIDTH)) u_step0 (
    .r_in    (r_q),
    .dvd_bit (q_q[QUOT_WIDTH-1]),
    .divisor (dsr_q),
    .r_out   (r_s0),
    .q_bit   (qb0)
  );

`ifdef DIVIDER_RADIX4_EN
  logic [DIV_WIDTH:0] r_s1;
  logic               qb1;

  if ((QUOT_WIDTH % 2) != 0) begin : g_odd_quot_width
    $error("restoring_divider_seq: QUOT_WIDTH must be even when two steps run per cycle");
  end

  div_step #(.DIV_WIDTH(DIV_WIDTH)) u_step1 (
    .r_in    (r_s0),
    .dvd_bit (q_q[QUOT_WIDTH-2]),
    .divisor (dsr_q),
    .r_out   (r_s1),
    .q_bit   (qb1)
  );

  assign r_nxt = r_s1;
  assign q_nxt = (q_q << 2) | QUOT_WIDTH'({qb0, qb1});
`else
  assign r_nxt = r_s0;
  assign q_nxt = (q_q << 1) | QUOT_WIDTH'(qb0);
`endif

  always_comb begin
    state_nxt = state;
    case (state)
      IDLE:    if (start) state_nxt = (in_dz || in_ovf) ? DONE : CALC;
      CALC:    if (cnt_q == '0) state_nxt = DONE;
      DONE:    state_nxt = IDLE;
      default: state_nxt = IDLE;
    endcase
  end

  // Control and result registers; results are only written on entry to DONE.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state       <= IDLE;
      cnt_q       <= '0;
      rdy         <= 1'b0;
      busy        <= 1'b0;
      quot        <= '0;
      rem         <= '0;
      div_by_zero <= 1'b0;
      overflow    <= 1'b0;
    end else begin
      state <= state_nxt;
      rdy   <= (state == DONE);
      busy  <= (state_nxt == CALC);
      if (accept) begin
        cnt_q       <= CNT_INIT;
        div_by_zero <= in_dz;
        overflow    <= in_ovf;
        if (in_dz) begin
          quot <= QUOT_ONES;
          rem  <= in0[DIV_WIDTH-1:0];
        end else if (in_ovf) begin
          quot <= QUOT_ONES;
          rem  <= '0;
        end
      end else if (state == CALC) begin
        cnt_q <= cnt_q - 1'b1;
        if (last_iter) begin
          quot <= q_nxt;
          rem  <= r_nxt[DIV_WIDTH-1:0];
        end
      end
    end
  end

  // Iteration datapath: partial remainder, dividend/quotient shifter, divisor.
  always_ff @(posedge clk) begin
    if (accept) begin
      dsr_q <= in1;
      r_q   <= {1'b0, dvd_hi};
      q_q   <= dvd_lo;
    end else if (state == CALC) begin
      r_q   <= r_nxt;
      q_q   <= q_nxt;
    end
  end

endmodule

// File: tb/tb_restoring_divider_seq.sv
// Self-checking bench for restoring_divider_seq: directed corner cases,
// handshake/reset behaviour and randomized a*b+r round trips.
module tb_restoring_divider_seq;

  localparam int QW = 64;
  localparam int DW = 64;
  localparam int VW = QW + DW;
`ifdef DIVIDER_RADIX4_EN
  localparam int LAT = QW / 2 + 1;
`else
  localparam int LAT = QW + 1;
`endif

  logic          clk = 1'b0;
  logic          rst;
  logic          start;
  logic [VW-1:0] in0;
  logic [DW-1:0] in1;
  logic [QW-1:0] quot;
  logic [DW-1:0] rem;
  logic          rdy;
  logic          busy;
  logic          div_by_zero;
  logic          overflow;

  int n_checks = 0;
  int n_fail   = 0;

  always #5 clk = ~clk;

  restoring_divider_seq #(.QUOT_WIDTH(QW), .DIV_WIDTH(DW)) dut (
    .clk         (clk),
    .rst         (rst),
    .start       (start),
    .in0         (in0),
    .in1         (in1),
    .quot        (quot),
    .rem         (rem),
    .rdy         (rdy),
    .busy        (busy),
    .div_by_zero (div_by_zero),
    .overflow    (overflow)
  );

  task automatic chk(input string tag, input logic [127:0] obs, input logic [127:0] exp);
    n_checks++;
    assert (obs === exp) else begin
      n_fail++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  // Reference: plain integer division with the saturating error rules.
  function automatic void ref_div(input logic [VW-1:0] a, input logic [DW-1:0] b,
                                  output logic [QW-1:0] q, output logic [DW-1:0] r,
                                  output logic dz, output logic ov);
    logic [VW-1:0] bw;
    logic [VW-1:0] qw;
    logic [VW-1:0] rw;
    bw = {{QW{1'b0}}, b};
    dz = 1'b0;
    ov = 1'b0;
    if (b == '0) begin
      dz = 1'b1;
      q  = '1;
      r  = a[DW-1:0];
    end else if (a[VW-1:QW] >= b) begin
      ov = 1'b1;
      q  = '1;
      r  = '0;
    end else begin
      qw = a / bw;
      rw = a % bw;
      q  = qw[QW-1:0];
      r  = rw[DW-1:0];
    end
  endfunction

  task automatic run_op(input logic [VW-1:0] a, input logic [DW-1:0] b, output int lat);
    @(negedge clk);
    in0   = a;
    in1   = b;
    start = 1'b1;
    @(posedge clk);
    #1;
    start = 1'b0;
    lat   = 0;
    while (!rdy && lat < 200) begin
      @(posedge clk);
      #1;
      lat++;
    end
  endtask

  task automatic check_vs_model(input string tag, input logic [VW-1:0] a, input logic [DW-1:0] b);
    logic [QW-1:0] eq;
    logic [DW-1:0] er;
    logic          edz;
    logic          eov;
    ref_div(a, b, eq, er, edz, eov);
    chk({tag, "_quot"}, 128'(quot), 128'(eq));
    chk({tag, "_rem"}, 128'(rem), 128'(er));
    chk({tag, "_dz"}, 128'(div_by_zero), 128'(edz));
    chk({tag, "_ovf"}, 128'(overflow), 128'(eov));
  endtask

  initial begin
    int            lat;
    int            rdy_cnt;
    logic [QW-1:0] ra;
    logic [DW-1:0] rb;
    logic [DW-1:0] rr;
    logic [VW-1:0] dvd;
    logic [VW-1:0] big;

    rst   = 1'b0;
    start = 1'b0;
    in0   = '0;
    in1   = '0;
    repeat (2) @(posedge clk);
    #1;
    chk("rst_quot", 128'(quot), 128'd0);
    chk("rst_rem", 128'(rem), 128'd0);
    chk("rst_rdy", 128'(rdy), 128'd0);
    chk("rst_busy", 128'(busy), 128'd0);
    chk("rst_dz", 128'(div_by_zero), 128'd0);
    chk("rst_ovf", 128'(overflow), 128'd0);
    @(negedge clk);
    rst = 1'b1;

    run_op(128'd100, 64'd7, lat);
    chk("lat_100_7", 128'(lat), 128'(LAT));
    chk("q_100_7", 128'(quot), 128'd14);
    chk("r_100_7", 128'(rem), 128'd2);
    check_vs_model("m_100_7", 128'd100, 64'd7);
    @(posedge clk);
    #1;
    chk("rdy_one_cycle", 128'(rdy), 128'd0);
    chk("quot_held", 128'(quot), 128'd14);

    big = 128'd5 << 64;
    run_op(big, 64'd6, lat);
    chk("lat_5s_6", 128'(lat), 128'(LAT));
    chk("q_5s_6", 128'(quot), 128'h0000_0000_0000_0000_D555_5555_5555_5555);
    chk("r_5s_6", 128'(rem), 128'd2);

    run_op(128'h1234, 64'd0, lat);
    chk("lat_dz", 128'(lat), 128'd1);
    chk("dz_flag", 128'(div_by_zero), 128'd1);
    chk("dz_ovf", 128'(overflow), 128'd0);
    chk("dz_quot", 128'(quot), 128'h0000_0000_0000_0000_FFFF_FFFF_FFFF_FFFF);
    chk("dz_rem", 128'(rem), 128'h1234);

    run_op(big, 64'd5, lat);
    chk("lat_ovf", 128'(lat), 128'd1);
    chk("ovf_flag", 128'(overflow), 128'd1);
    chk("ovf_dz", 128'(div_by_zero), 128'd0);
    chk("ovf_quot", 128'(quot), 128'h0000_0000_0000_0000_FFFF_FFFF_FFFF_FFFF);
    chk("ovf_rem", 128'(rem), 128'd0);

    run_op(128'd100, 64'd7, lat);
    check_vs_model("clr_100_7", 128'd100, 64'd7);

    // Start held high for the whole operation with changing operands.
    @(negedge clk);
    in0   = 128'd100;
    in1   = 64'd7;
    start = 1'b1;
    @(posedge clk);
    #1;
    chk("storm_busy", 128'(busy), 128'd1);
    in0 = 128'd999;
    in1 = 64'd3;
    lat = 0;
    while (!rdy && lat < 200) begin
      @(posedge clk);
      #1;
      lat++;
    end
    start   = 1'b0;
    rdy_cnt = rdy ? 1 : 0;
    chk("storm_lat", 128'(lat), 128'(LAT));
    chk("storm_quot", 128'(quot), 128'd14);
    chk("storm_rem", 128'(rem), 128'd2);
    repeat (LAT + 5) begin
      @(posedge clk);
      #1;
      if (rdy) rdy_cnt++;
    end
    chk("storm_rdy_count", 128'(rdy_cnt), 128'd1);

    // Reset in the middle of an operation.
    run_op(128'd100, 64'd7, lat);
    @(negedge clk);
    in0   = big;
    in1   = 64'd6;
    start = 1'b1;
    @(posedge clk);
    #1;
    start = 1'b0;
    repeat (30) @(posedge clk);
    @(negedge clk);
    rst = 1'b0;
    #1;
    chk("mid_rst_quot", 128'(quot), 128'd0);
    chk("mid_rst_rem", 128'(rem), 128'd0);
    chk("mid_rst_rdy", 128'(rdy), 128'd0);
    chk("mid_rst_busy", 128'(busy), 128'd0);
    chk("mid_rst_flags", 128'({div_by_zero, overflow}), 128'd0);
    rdy_cnt = 0;
    repeat (2) @(negedge clk);
    rst = 1'b1;
    repeat (LAT + 10) begin
      @(posedge clk);
      #1;
      if (rdy || busy) rdy_cnt++;
    end
    chk("mid_rst_no_rdy", 128'(rdy_cnt), 128'd0);
    run_op(big, 64'd6, lat);
    chk("post_rst_lat", 128'(lat), 128'(LAT));
    check_vs_model("post_rst", big, 64'd6);

    for (int i = 0; i < 1000; i++) begin
      ra = {$urandom, $urandom};
      if (i % 4 == 0) rb = 64'($urandom_range(255, 1));
      else            rb = {$urandom, $urandom};
      if (rb == '0) rb = 64'd1;
      rr  = {$urandom, $urandom} % rb;
      dvd = {{DW{1'b0}}, ra} * {{QW{1'b0}}, rb} + {{QW{1'b0}}, rr};
      run_op(dvd, rb, lat);
      chk($sformatf("rnd%0d_lat", i), 128'(lat), 128'(LAT));
      chk($sformatf("rnd%0d_quot", i), 128'(quot), 128'(ra));
      chk($sformatf("rnd%0d_rem", i), 128'(rem), 128'(rr));
      chk($sformatf("rnd%0d_flags", i), 128'({div_by_zero, overflow}), 128'd0);
    end

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
